mdu_iter: RTL
=============

Name: mdu_iter

Overview:
- Iterative multiply/divide unit for the integer pipeline.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Produces a 64-bit {hi,lo} result plus per-half write enables. These feed the HI/LO register pair directly downstream.
- Holds a `busy` stall toward issue while an operation is in flight.

Parameters:
- XLEN, 32, operand width; result is 2*XLEN.
- ITER, 32, iterations for the radix-2 multiply and divide loops; must equal XLEN.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset (synchronous, active-low)
- start  in  1  request; accepted only when `busy`=0
- op  in  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6/7 reserved, treated as no-op
- src_a  in  32  multiplicand / dividend / move source
- src_b  in  32  multiplier / divisor
- flush  in  1  pipeline cancel
- busy  out  1  operation in flight, stall issue
- done  out  1  one-cycle completion pulse
- wen_hiol  out  2  bit0 writes hi (result[63:32]), bit1 writes lo (result[31:0])
- result  out  64  {hi,lo}

Behaviour:
- Clocking and reset:
  - Reset is rst_n, synchronous, active-low; clock is clk.
  - Reset forces state IDLE and clears all registers.
  - Reset values: `busy`=0, `done`=0, `wen_hiol`=2'b00, `result`=0.
  - Reset mid-operation aborts the operation with no `done`.
- States: IDLE, RUN, FIX, DONE.
- Outputs by state:
  - `busy` = (RUN or FIX).
  - `done` = (DONE).
  - `wen_hiol` = 2'b00 outside DONE.
  - `result` holds its last value outside DONE.
- Transitions and latency:
  - IDLE or DONE with `start` and op 0-3 → RUN. Operands are captured at that edge; the iteration counter is cleared.
  - RUN lasts exactly ITER cycles, then → FIX, which does sign correction for one cycle, then → DONE.
  - `start` in cycle 0 gives `done` in cycle 34.
- Fast paths:
  - MTHI: start → DONE next cycle; `result`={src_a,src_a}; `wen_hiol`=2'b01.
  - MTLO: same as MTHI but `wen_hiol`=2'b10.
  - DIV/DIVU with `src_b`==0: → DONE next cycle; hi=`src_a`, lo=32'hFFFFFFFF; `wen_hiol`=2'b11.
- MUL/DIV completion: `wen_hiol`=2'b11.
- DONE returns to IDLE unless a new `start` is accepted in that same cycle (back-to-back allowed).
- `start` while `busy`=1 is ignored, with no queueing.
- Reserved ops are accepted as no-ops and stay in IDLE.
- Multiply:
  - Shift-add on magnitudes, 1 bit per RUN cycle, into a 64-bit accumulator.
  - Signed: operands are made absolute at capture; the product is negated in FIX if sign_a^sign_b.
- Divide:
  - Restoring divide on magnitudes, 1 quotient bit per cycle.
  - Quotient sign = sign_a^sign_b; remainder sign = sign_a. Applied in FIX.
  - DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (32-bit wrap).
- Flush:
  - From RUN or FIX: → IDLE at the next edge, no `done`, no write.
  - In DONE: the write still occurs (commit point); next state is IDLE.
  - `flush` and `start` in the same cycle: flush wins, start is dropped.

Optional Feature:
- Macro MDU_FAST_MUL_EN.
- Defined: MULT/MULTU compute the full signed/unsigned product in one cycle. The product is registered: start → DONE next cycle, `done` in cycle 1; RUN and FIX are not used for multiply.
- Undefined: multiply uses the 34-cycle iterative path. Divide behaviour is unchanged either way.

Decomposition:
- Shared package mdu_pkg contains:
  - op encodings (OP_MULT..OP_MTLO)
  - state enum
  - WEN_HI=2'b01, WEN_LO=2'b10, WEN_BOTH=2'b11
  - ITER constant
- Natural sub-module: mdu_div_step. It is the combinational restoring-divide step (partial remainder, divisor → next remainder, quotient bit), instantiated once and used each RUN cycle.
- Counter, FSM and sign logic stay in mdu_iter.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `result`=64'hFFFFFFFE_00000001, `wen_hiol`=11, `done` in cycle 34 (cycle 1 with MDU_FAST_MUL_EN); `busy` high in cycles 1-33.
- MULT −3 × 5 → `result`=64'hFFFFFFFF_FFFFFFF1. DIV −7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7 / 2 → lo=3, hi=1.
- DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0. DIVU 0x55 / 0 → `done` in cycle 1, hi=0x55, lo=0xFFFFFFFF.
- MTHI 0x1234 → `done` in cycle 1, `wen_hiol`=01, `result`[63:32]=0x1234. MTLO → `wen_hiol`=10. A second `start` pulsed during a busy DIV is ignored, giving exactly one `done`.
- DIV started; `flush` in cycle 10 → `busy`=0 in cycle 11, no `done`/`wen` ever. `rst_n`=0 in cycle 20 of a MULTU → all outputs 0 next cycle, no `done`.
- Back-to-back: new `start` in the DONE cycle → accepted; the second `done` arrives 34 cycles later with correct result.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared constants, op encodings and FSM states for the iterative multiply/divide unit.
package mdu_pkg;

  localparam int XLEN = 32;
  localparam int ITER = 32;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [1:0] WEN_HI   = 2'b01;
  localparam logic [1:0] WEN_LO   = 2'b10;
  localparam logic [1:0] WEN_BOTH = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// Request/response bundle between issue logic and the multiply/divide unit.
interface mdu_iter_if;
  import mdu_pkg::*;

  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            flush;
  logic            busy;
  logic            done;
  logic [1:0]      wen_hiol;
  logic [2*XLEN-1:0] result;

  modport master (
    output start, op, src_a, src_b, flush,
    input  busy, done, wen_hiol, result
  );

  modport slave (
    input  start, op, src_a, src_b, flush,
    output busy, done, wen_hiol, result
  );

endinterface

// File: rtl/mdu_div_step.sv
// One restoring-divide step: shift in the next dividend bit, subtract the divisor if it fits.
module mdu_div_step
  import mdu_pkg::*;
(
  input  logic [XLEN-1:0] rem_in,
  input  logic            next_bit,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic            q_bit
);

  logic [XLEN:0] trial;
  logic [XLEN:0] diff;

  // rem_in < divisor always holds, so a successful subtract never sets the top bit
  always_comb begin
    trial   = {rem_in, next_bit};
    diff    = trial - {1'b0, divisor};
    q_bit   = ~diff[XLEN];
    rem_out = q_bit ? diff[XLEN-1:0] : trial[XLEN-1:0];
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU/MTHI/MTLO unit producing {hi,lo} plus per-half write enables.
// Define MDU_FAST_MUL_EN for a single-cycle registered multiply.
module mdu_iter
  import mdu_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  mdu_iter_if.slave bus
);

  localparam int CNT_W = $clog2(ITER);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [2:0]          op_q;
  logic                sign_a_q, sign_b_q;
  logic [2*XLEN-1:0]   mcand_q, acc_q, result_q;
  logic [XLEN-1:0]     mplier_q;
  logic [1:0]          wen_q;

  logic                accept, neg_a, neg_b, is_div_op, is_div_q;
  logic [XLEN-1:0]     mag_a, mag_b, rem_next, quot, rem;
  logic                q_bit;
  logic [2*XLEN-1:0]   fast_res, fixed_res;
  logic [1:0]          fast_wen;

  assign accept    = bus.start && !bus.flush && (state_q == IDLE || state_q == DONE);
  assign is_div_op = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
  assign is_div_q  = (op_q == OP_DIV) || (op_q == OP_DIVU);
  assign neg_a     = is_signed_op(bus.op) && bus.src_a[XLEN-1];
  assign neg_b     = is_signed_op(bus.op) && bus.src_b[XLEN-1];
  assign mag_a     = neg_a ? -bus.src_a : bus.src_a;
  assign mag_b     = neg_b ? -bus.src_b : bus.src_b;

  mdu_div_step u_div_step (
    .rem_in   (acc_q[2*XLEN-1:XLEN]),
    .next_bit (acc_q[XLEN-1]),
    .divisor  (mplier_q),
    .rem_out  (rem_next),
    .q_bit    (q_bit)
  );

`ifdef MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] prod_s, prod_u;
  assign prod_s = $signed({{XLEN{bus.src_a[XLEN-1]}}, bus.src_a}) *
                  $signed({{XLEN{bus.src_b[XLEN-1]}}, bus.src_b});
  assign prod_u = {{XLEN{1'b0}}, bus.src_a} * {{XLEN{1'b0}}, bus.src_b};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Flush always wins; it is already folded into accept for the IDLE/DONE states
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          case (bus.op)
`ifdef MDU_FAST_MUL_EN
            OP_MULT, OP_MULTU: state_d = DONE;
`else
            OP_MULT, OP_MULTU: state_d = RUN;
`endif
            OP_DIV, OP_DIVU:   state_d = (bus.src_b == '0) ? DONE : RUN;
            OP_MTHI, OP_MTLO:  state_d = DONE;
            default:           state_d = IDLE;
          endcase
        end
      end
      RUN:     state_d = bus.flush ? IDLE : ((cnt_q == CNT_W'(ITER-1)) ? FIX : RUN);
      FIX:     state_d = bus.flush ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy     = (state_q == RUN) || (state_q == FIX);
    bus.done     = (state_q == DONE);
    bus.wen_hiol = (state_q == DONE) ? wen_q : 2'b00;
    bus.result   = result_q;
  end

  always_comb begin
    fast_res = '0;
    fast_wen = 2'b00;
    case (bus.op)
      OP_MTHI:         begin fast_res = {bus.src_a, bus.src_a}; fast_wen = WEN_HI;   end
      OP_MTLO:         begin fast_res = {bus.src_a, bus.src_a}; fast_wen = WEN_LO;   end
      OP_DIV, OP_DIVU: begin fast_res = {bus.src_a, {XLEN{1'b1}}}; fast_wen = WEN_BOTH; end
`ifdef MDU_FAST_MUL_EN
      OP_MULT:         begin fast_res = prod_s; fast_wen = WEN_BOTH; end
      OP_MULTU:        begin fast_res = prod_u; fast_wen = WEN_BOTH; end
`endif
      default:         ;
    endcase
  end

  // Signs were stripped at capture; restore them once the magnitude loop is finished
  always_comb begin
    quot = acc_q[XLEN-1:0];
    rem  = acc_q[2*XLEN-1:XLEN];
    if (is_div_q)
      fixed_res = {sign_a_q ? -rem : rem, (sign_a_q ^ sign_b_q) ? -quot : quot};
    else
      fixed_res = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
  end

  // For divide acc holds {partial remainder, dividend shifting out / quotient shifting in}
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      op_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      result_q <= '0;
      wen_q    <= 2'b00;
    end else if (accept) begin
      op_q     <= bus.op;
      sign_a_q <= neg_a;
      sign_b_q <= neg_b;
      cnt_q    <= '0;
      mcand_q  <= {{XLEN{1'b0}}, mag_a};
      mplier_q <= mag_b;
      acc_q    <= is_div_op ? {{XLEN{1'b0}}, mag_a} : '0;
      if (state_d == DONE) begin
        result_q <= fast_res;
        wen_q    <= fast_wen;
      end
    end else if (state_q == RUN) begin
      cnt_q <= cnt_q + 1'b1;
      if (is_div_q) begin
        acc_q <= {rem_next, acc_q[XLEN-2:0], q_bit};
      end else begin
        if (mplier_q[0]) acc_q <= acc_q + mcand_q;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
      end
    end else if (state_q == FIX && state_d == DONE) begin
      result_q <= fixed_res;
      wen_q    <= WEN_BOTH;
    end
  end

endmodule
